rowo_dpram_async: RTL and testbench
===================================

Name: rowo_dpram_async

Overview:
- Simple dual-port RAM: one write port and one read port, each on its own independent clock.
- Read port returns old data on a collision; write port has no read-back.
- Acts as the storage element of the PCM clock-domain-crossing FIFO. The write side sits in the PCM capture domain; the read side sits in the register/stream output domain.
- Write and read words may differ in width by a power-of-two ratio.

Parameters:
- rdw, 16, read data width in bits.
- wdw, 16, write data width in bits. max(rdw,wdw)/min(rdw,wdw) must be a power of two (1, 2, 4, 8).
- raw, 9, read address width. Depth is 2^raw read words.
- Derived localparam waw = raw + log2(rdw/wdw) when rdw>=wdw, else raw - log2(wdw/rdw). Total storage is always 2^raw*rdw bits.

Ports:
- pcm_in_clk  in  1  write clock; also samples rst
- rdclock  in  1  read clock, asynchronous to pcm_in_clk
- rst  in  1  reset rst, synchronous, active-high; clock pcm_in_clk
- data  in  wdw  write data
- wraddress  in  waw  write address
- wren  in  1  write enable
- rdaddress  in  raw  read address
- rden  in  1  read enable
- q  out  rdw  registered read data

Behaviour:
- Write: on a pcm_in_clk rising edge with wren=1, store data at wraddress. Writes are not affected by rst. Memory contents are never cleared.
- Read: on a rdclock rising edge with rden=1, q <= mem[rdaddress]. Latency is exactly 1 rdclock cycle. With rden=0, q holds its value.
- Reset: rst is passed through a 2-flop synchronizer into the rdclock domain. While the synchronized rst is high, q <= 0 and read enables are ignored. Reset value of q is 0. The caller holds rst for at least 3 cycles of the slower clock. Asserting rst mid-operation clears q only; stored data is kept.
- Mixed width, rdw>wdw: one read word holds R=rdw/wdw write words. Write address w maps to read word w>>log2(R), bit slice (w mod R)*wdw. Lower write addresses occupy lower q bits (little-endian).
- Mixed width, wdw>rdw: one write word holds R=wdw/rdw read words. Read address r returns slice (r mod R)*rdw of write word r>>log2(R).
- Equal widths: plain RAM, waw=raw.
- Collision (same location written and read on coincident edges): q returns the old (pre-write) contents. For truly asynchronous clocks the collision result is old or new data, never a bit-mix of the two. The FIFO above avoids this case by design.
- Address wrap-around: addresses are used modulo depth. There are no out-of-range checks.
- Inference: the array must map to block RAM. No combinational path from any input to q.

Optional Feature:
- Macro RDPRAM_OUTREG_EN.
- When defined: adds a second register stage after q, clocked by rdclock with the same rden qualifier pipelined by one cycle. Read latency becomes 2 rdclock cycles. rst clears both stages.
- When undefined (default): read latency is 1 cycle, as above. The FIFO wrapper requires the undefined build.

Decomposition:
- Shared package pcm_pkg: PCM_W=16 sample width, default depth constant PCM_AW=9, and a clog2-style function used for the waw derivation.
- One sub-module: rst_sync_2ff, the 2-flop reset synchronizer into rdclock. The RAM array and read registers stay in the top module.

Test Plan:
1. Equal widths 16/16, raw=9, same clock. Write 0x1234 @5, then rden @5 one cycle later -> q=0x1234 exactly 1 rdclock edge after rden. q holds while rden=0.
2. Async clocks (pcm_in_clk 10 ns, rdclock 13 ns). Write 512 incrementing values 0..511, then read addresses 0..511 -> q equals the address each time. Address 512 wraps to 0.
3. Same clock, addr 7 holds 0xAAAA. Write 0x5555 and read addr 7 on the same edge -> q=0xAAAA. Next read -> 0x5555.
4. wdw=8, rdw=16. Write 0x11 @0 and 0x22 @1, then read @0 -> q=0x2211.
5. q=0xBEEF, assert rst for 4 cycles -> q=0 within 3 rdclock edges. Then read the previously written addr -> original data intact.
6. RDPRAM_OUTREG_EN defined. Read addr 5 (value 0x00C3) -> q=0x00C3 exactly 2 rdclock edges after rden.

Source files
------------

// File: rtl/pcm_pkg.sv
// pcm_pkg: constants and helpers shared by the PCM capture / CDC FIFO blocks.
//   PCM_W      - PCM sample width in bits
//   PCM_AW     - default storage address width (depth 2^PCM_AW samples)
//   pcm_clog2  - ceiling log2 for elaboration-time width derivation
//   pcm_waw    - write address width of a mixed-width RAM from its read geometry
`timescale 1ns/100ps
package pcm_pkg;

   localparam int PCM_W  = 16;
   localparam int PCM_AW = 9;

   function automatic int pcm_clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // Total storage stays 2^r_aw * r_w bits, so the write side gains (or loses)
   // address bits in proportion to the width ratio.
   function automatic int pcm_waw(input int r_w, input int w_w, input int r_aw);
      if (r_w >= w_w) return r_aw + pcm_clog2(r_w / w_w);
      else            return r_aw - pcm_clog2(w_w / r_w);
   endfunction

endpackage

// File: rtl/rst_sync_2ff.sv
// rst_sync_2ff: two-flop synchronizer carrying an active-high reset into a
// foreign clock domain. Assertion and deassertion both take two clk_i edges.
//   clk_i      - destination clock
//   rst_i      - reset from the source domain
//   rst_sync_o - reset synchronized to clk_i
`timescale 1ns/100ps
module rst_sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   output logic rst_sync_o
);

   logic [1:0] sync_q;
   logic [1:0] sync_d;

   assign sync_d = {sync_q[0], rst_i};

   always_ff @(posedge clk_i) begin
      sync_q <= sync_d;
   end

   assign rst_sync_o = sync_q[1];

endmodule

// File: rtl/rowo_dpram_async.sv
// rowo_dpram_async: simple dual-port RAM, one write port on pcm_in_clk and one
// registered read port on rdclock. Storage element of the PCM CDC FIFO.
// Read returns old data on a same-location collision. Write and read widths may
// differ by a power-of-two ratio; narrower words pack little-endian.
//   pcm_in_clk - write clock, also samples rst
//   rdclock    - read clock, asynchronous to pcm_in_clk
//   rst        - synchronous active-high reset (pcm_in_clk domain); clears q only
//   data       - write data (wdw bits)
//   wraddress  - write address (waw bits)
//   wren       - write enable
//   rdaddress  - read address (raw bits)
//   rden       - read enable
//   q          - registered read data (rdw bits)
// Build option: RDPRAM_OUTREG_EN adds a second output register (latency 2).
`timescale 1ns/100ps
module rowo_dpram_async
   import pcm_pkg::*;
#(
   parameter  int rdw = PCM_W,
   parameter  int wdw = PCM_W,
   parameter  int raw = PCM_AW,
   localparam int waw = pcm_waw(rdw, wdw, raw)
) (
   input  logic           pcm_in_clk,
   input  logic           rdclock,
   input  logic           rst,
   input  logic [wdw-1:0] data,
   input  logic [waw-1:0] wraddress,
   input  logic           wren,
   input  logic [raw-1:0] rdaddress,
   input  logic           rden,
   output logic [rdw-1:0] q
);

   // The array is kept at the wider of the two word sizes so the narrow side
   // becomes a lane-select on write or a slice-select on read.
   localparam int MW  = (rdw >= wdw) ? rdw : wdw;
   localparam int MAW = (rdw >= wdw) ? raw : waw;

   logic [MW-1:0]  mem [2**MAW];
   logic           rst_rd;
   logic [rdw-1:0] q1_q;

   rst_sync_2ff u_rst_sync (
      .clk_i      (rdclock),
      .rst_i      (rst),
      .rst_sync_o (rst_rd)
   );

   // Write port: never reset, contents survive rst.
   if (rdw > wdw) begin : g_wr_pack
      localparam int LG = pcm_clog2(rdw / wdw);
      always_ff @(posedge pcm_in_clk) begin
         if (wren) mem[wraddress[waw-1:LG]][wraddress[LG-1:0]*wdw +: wdw] <= data;
      end
   end else begin : g_wr_full
      always_ff @(posedge pcm_in_clk) begin
         if (wren) mem[wraddress] <= data;
      end
   end

   // Read port: synchronous read, so no input reaches q combinationally.
   if (wdw > rdw) begin : g_rd_unpack
      localparam int LG = pcm_clog2(wdw / rdw);
      always_ff @(posedge rdclock) begin
         if (rst_rd)    q1_q <= '0;
         else if (rden) q1_q <= mem[rdaddress[raw-1:LG]][rdaddress[LG-1:0]*rdw +: rdw];
      end
   end else begin : g_rd_full
      always_ff @(posedge rdclock) begin
         if (rst_rd)    q1_q <= '0;
         else if (rden) q1_q <= mem[rdaddress];
      end
   end

`ifdef RDPRAM_OUTREG_EN
   logic [rdw-1:0] q2_q;
   logic           rden_q;

   // The second stage follows the first only on cycles where the first loaded.
   always_ff @(posedge rdclock) begin
      if (rst_rd) begin
         q2_q   <= '0;
         rden_q <= 1'b0;
      end else begin
         rden_q <= rden;
         if (rden_q) q2_q <= q1_q;
      end
   end

   assign q = q2_q;
`else
   assign q = q1_q;
`endif

endmodule

// File: tb/tb_rowo_dpram_async.sv
`timescale 1ns/100ps
module tb_rowo_dpram_async;

`ifdef RDPRAM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic pcm_in_clk  = 1'b0;
   logic rdclk_async = 1'b0;
   logic same_clk    = 1'b1;
   logic rdclock;
   logic rst         = 1'b1;

   always #5 pcm_in_clk = ~pcm_in_clk;
   initial begin
      #3;
      forever #6.5 rdclk_async = ~rdclk_async;
   end
   assign rdclock = same_clk ? pcm_in_clk : rdclk_async;

   // A: 16/16, B: wdw=8 rdw=16, C: wdw=16 rdw=8
   logic [15:0] dA = '0; logic [8:0] waA = '0; logic wenA = 1'b0;
   logic [8:0]  raA = '0; logic renA = 1'b0; logic [15:0] qA;
   logic [7:0]  dB = '0; logic [9:0] waB = '0; logic wenB = 1'b0;
   logic [8:0]  raB = '0; logic renB = 1'b0; logic [15:0] qB;
   logic [15:0] dC = '0; logic [7:0] waC = '0; logic wenC = 1'b0;
   logic [8:0]  raC = '0; logic renC = 1'b0; logic [7:0]  qC;

   rowo_dpram_async #(.rdw(16), .wdw(16), .raw(9)) u_dut_a (
      .pcm_in_clk(pcm_in_clk), .rdclock(rdclock), .rst(rst),
      .data(dA), .wraddress(waA), .wren(wenA),
      .rdaddress(raA), .rden(renA), .q(qA));

   rowo_dpram_async #(.rdw(16), .wdw(8), .raw(9)) u_dut_b (
      .pcm_in_clk(pcm_in_clk), .rdclock(rdclock), .rst(rst),
      .data(dB), .wraddress(waB), .wren(wenB),
      .rdaddress(raB), .rden(renB), .q(qB));

   rowo_dpram_async #(.rdw(8), .wdw(16), .raw(9)) u_dut_c (
      .pcm_in_clk(pcm_in_clk), .rdclock(rdclock), .rst(rst),
      .data(dC), .wraddress(waC), .wren(wenC),
      .rdaddress(raC), .rden(renC), .q(qC));

   int n_tests = 0;
   int n_fail  = 0;

   // Reference: each RAM is a flat bit string of 2^raw*rdw bits; a word of
   // width W at address a occupies bits [a*W +: W], modulo the total size.
   logic [8191:0] mA, mB;
   logic [4095:0] mC;

   function automatic void mwrite(input int d, input int addr, input logic [15:0] v);
      int ww, tot, base;
      ww  = (d == 1) ? 8 : 16;
      tot = (d == 2) ? 4096 : 8192;
      base = (addr * ww) % tot;
      for (int i = 0; i < ww; i++) begin
         case (d)
            0:       mA[base+i] = v[i];
            1:       mB[base+i] = v[i];
            default: mC[base+i] = v[i];
         endcase
      end
   endfunction

   function automatic logic [15:0] mread(input int d, input int addr);
      int rw, tot, base;
      logic [15:0] r;
      rw  = (d == 2) ? 8 : 16;
      tot = (d == 2) ? 4096 : 8192;
      base = (addr * rw) % tot;
      r = '0;
      for (int i = 0; i < rw; i++) begin
         case (d)
            0:       r[i] = mA[base+i];
            1:       r[i] = mB[base+i];
            default: r[i] = mC[base+i];
         endcase
      end
      return r;
   endfunction

   function automatic logic [15:0] getq(input int d);
      case (d)
         0:       return qA;
         1:       return qB;
         default: return {8'h00, qC};
      endcase
   endfunction

   task automatic wr(input int d, input int addr, input logic [15:0] v);
      @(negedge pcm_in_clk);
      case (d)
         0: begin dA = v;      waA = addr[8:0]; wenA = 1'b1; end
         1: begin dB = v[7:0]; waB = addr[9:0]; wenB = 1'b1; end
         default: begin dC = v; waC = addr[7:0]; wenC = 1'b1; end
      endcase
      @(posedge pcm_in_clk);
      mwrite(d, addr, v);
      #1;
      wenA = 1'b0; wenB = 1'b0; wenC = 1'b0;
   endtask

   task automatic rd(input int d, input int addr, input string name);
      logic [15:0] expv, prev;
      expv = mread(d, addr);
      @(negedge rdclock);
      prev = getq(d);
      case (d)
         0: begin raA = addr[8:0]; renA = 1'b1; end
         1: begin raB = addr[8:0]; renB = 1'b1; end
         default: begin raC = addr[8:0]; renC = 1'b1; end
      endcase
      @(posedge rdclock);
      #1;
      renA = 1'b0; renB = 1'b0; renC = 1'b0;
`ifdef RDPRAM_OUTREG_EN
      if (prev !== expv) begin
         n_tests++;
         if (getq(d) !== prev) begin
            n_fail++;
            $display("FAIL %s_early addr=%0d got %h required %h (one edge after rden)",
                     name, addr, getq(d), prev);
         end
      end
      @(posedge rdclock);
      #1;
`endif
      n_tests++;
      if (getq(d) !== expv) begin
         n_fail++;
         $display("FAIL %s addr=%0d got %h required %h", name, addr, getq(d), expv);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (6) @(posedge rdclock);
      #1;
      n_tests++;
      if (qA !== 16'h0000) begin n_fail++; $display("FAIL reset_qA got %h required 0000", qA); end
      n_tests++;
      if (qB !== 16'h0000) begin n_fail++; $display("FAIL reset_qB got %h required 0000", qB); end
      n_tests++;
      if (qC !== 8'h00) begin n_fail++; $display("FAIL reset_qC got %h required 00", qC); end
      @(negedge pcm_in_clk);
      rst = 1'b0;
      repeat (4) @(posedge rdclock);
   endtask

   task automatic test_basic();
      wr(0, 5, 16'h1234);
      rd(0, 5, "basic_read");
      @(negedge rdclock);
      raA = 9'd100;
      for (int i = 0; i < 3; i++) begin
         @(posedge rdclock);
         #1;
         n_tests++;
         if (qA !== 16'h1234) begin
            n_fail++;
            $display("FAIL basic_hold cycle=%0d got %h required 1234", i, qA);
         end
      end
   endtask

   task automatic test_collision();
      logic [15:0] old_v;
      wr(0, 7, 16'hAAAA);
      @(negedge pcm_in_clk);
      old_v = mread(0, 7);
      waA = 9'd7; dA = 16'h5555; wenA = 1'b1;
      raA = 9'd7; renA = 1'b1;
      @(posedge pcm_in_clk);
      mwrite(0, 7, 16'h5555);
      #1;
      wenA = 1'b0; renA = 1'b0;
`ifdef RDPRAM_OUTREG_EN
      @(posedge rdclock);
      #1;
`endif
      n_tests++;
      if (qA !== old_v) begin
         n_fail++;
         $display("FAIL collision_old got %h required %h", qA, old_v);
      end
      rd(0, 7, "collision_after");
   endtask

   task automatic test_mixed_width();
      wr(1, 0, 16'h0011);
      wr(1, 1, 16'h0022);
      rd(1, 0, "pack_w8_r16");
      n_tests++;
      if (qB !== 16'h2211) begin n_fail++; $display("FAIL pack_literal got %h required 2211", qB); end
      wr(2, 3, 16'hA1B2);
      rd(2, 6, "unpack_lo");
      rd(2, 7, "unpack_hi");
   endtask

   task automatic test_async_fill();
      for (int i = 0; i < 512; i++) wr(0, i, i[15:0]);
      for (int i = 0; i < 512; i++) rd(0, i, "async_seq");
      rd(0, 512, "async_wrap");
      for (int i = 0; i < 1024; i++) wr(1, i, 16'($urandom));
      for (int i = 0; i < 256; i++)  wr(2, i, 16'($urandom));
      for (int i = 0; i < 300; i++) begin
         if (i % 2 == 0) wr(1, int'($urandom_range(0, 1023)), 16'($urandom));
         else            wr(2, int'($urandom_range(0, 255)), 16'($urandom));
      end
      for (int i = 0; i < 200; i++) begin
         rd(1, int'($urandom_range(0, 511)), "rand_pack");
         rd(2, int'($urandom_range(0, 511)), "rand_unpack");
      end
   endtask

   task automatic test_reset_midop();
      wr(0, 9, 16'hBEEF);
      rd(0, 9, "rst_pre");
      @(negedge rdclock);
      rst = 1'b1;
      @(posedge rdclock);
      @(posedge rdclock);
      #1;
      n_tests++;
      if (qA !== 16'hBEEF) begin n_fail++; $display("FAIL rst_sync_delay got %h required beef", qA); end
      @(posedge rdclock);
      #1;
      n_tests++;
      if (qA !== 16'h0000) begin n_fail++; $display("FAIL rst_clear got %h required 0000", qA); end
      @(negedge rdclock);
      raA = 9'd9; renA = 1'b1;
      repeat (3) @(posedge rdclock);
      #1;
      renA = 1'b0;
      n_tests++;
      if (qA !== 16'h0000) begin n_fail++; $display("FAIL rst_rden_ignored got %h required 0000", qA); end
      @(negedge pcm_in_clk);
      rst = 1'b0;
      repeat (4) @(posedge rdclock);
      rd(0, 9, "rst_data_kept");
   endtask

   task automatic test_latency();
      wr(0, 5, 16'h00C3);
      rd(0, 5, "latency_read");
   endtask

   initial begin
      mA = '0; mB = '0; mC = '0;
      test_reset();
      test_basic();
      test_collision();
      test_mixed_width();
      same_clk = 1'b0;
      repeat (3) @(posedge rdclock);
      test_async_fill();
      test_reset_midop();
      test_latency();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL timeout tests=%0d failed=%0d (run did not complete)", n_tests, n_fail);
      $fatal(1, "timeout");
   end

endmodule
